// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue:
// bundle layout {adef, inst, pc} and default sizing.
package inst_fetch_queue_pkg;

   localparam int IFQ_BUS_W = 65;
   localparam int IFQ_DEPTH = 4;

   localparam int ADEF_BIT = 64;
   localparam int INST_HI  = 63;
   localparam int INST_LO  = 32;
   localparam int PC_HI    = 31;
   localparam int PC_LO    = 0;

endpackage : inst_fetch_queue_pkg

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side push, decode-side pop and redirect signals of the instruction queue.
// The master modport is the pipeline around the queue; the slave modport is the queue.
interface inst_fetch_queue_if
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int BUS_W = IFQ_BUS_W
);
   logic                     fs_to_ds_valid;
   logic [BUS_W-1:0]         fs_to_ds_bus;
   logic                     ifq_allowin;
   logic                     ds_allowin;
   logic                     q_to_ds_valid;
   logic [BUS_W-1:0]         q_to_ds_bus;
   logic                     wb_ex;
   logic                     ertn_flush;
   logic                     br_taken;
   logic [$clog2(DEPTH):0]   ifq_count;

   modport master (
      output fs_to_ds_valid, fs_to_ds_bus, ds_allowin, wb_ex, ertn_flush, br_taken,
      input  ifq_allowin, q_to_ds_valid, q_to_ds_bus, ifq_count
   );

   modport slave (
      input  fs_to_ds_valid, fs_to_ds_bus, ds_allowin, wb_ex, ertn_flush, br_taken,
      output ifq_allowin, q_to_ds_valid, q_to_ds_bus, ifq_count
   );

endinterface : inst_fetch_queue_if

// File: rtl/inst_fetch_queue.sv
// In-order decoupling queue between fetch and decode. Any redirect empties it,
// and an address-error bundle blocks further pushes until the next redirect.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int BUS_W = IFQ_BUS_W
)(
   input logic               clk,
   input logic               resetn,
   inst_fetch_queue_if.slave ifq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [BUS_W-1:0] storage_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             ex_hold_r;

   logic             flush_s;
   logic             full_s;
   logic             empty_s;
   logic             allowin_s;
   logic             valid_s;
   logic             push_s;
   logic             pop_s;
   logic [CNT_W-1:0] count_nxt_s;

   // Handshake decode; only registered state and redirect inputs feed allowin/valid.
   always_comb begin
      flush_s   = ifq.wb_ex | ifq.ertn_flush | ifq.br_taken;
      full_s    = (count_r == CNT_W'(DEPTH));
      empty_s   = (count_r == {CNT_W{1'b0}});
      allowin_s = ~full_s & ~ex_hold_r;
      valid_s   = ~empty_s & ~flush_s;
      push_s    = ifq.fs_to_ds_valid & allowin_s & ~flush_s;
      pop_s     = valid_s & ifq.ds_allowin;
   end

   // Occupancy next value: simultaneous push and pop leave it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer, occupancy and address-error hold registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_r    <= {PTR_W{1'b0}};
         tail_r    <= {PTR_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         ex_hold_r <= 1'b0;
      end else if (flush_s) begin
         head_r    <= {PTR_W{1'b0}};
         tail_r    <= {PTR_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         ex_hold_r <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
            if (ifq.fs_to_ds_bus[ADEF_BIT]) begin
               ex_hold_r <= 1'b1;
            end
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
      end
   end

   // Entry storage; a redirect leaves old contents in place since pointers are reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage_r[i] <= {BUS_W{1'b0}};
         end
      end else if (push_s) begin
         storage_r[tail_r] <= ifq.fs_to_ds_bus;
      end
   end

   assign ifq.ifq_allowin   = allowin_s;
   assign ifq.q_to_ds_valid = valid_s;
   assign ifq.q_to_ds_bus   = storage_r[head_r];
   assign ifq.ifq_count     = count_r;

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4): streaming,
// fill/wrap, redirect flushes, address-error hold and asynchronous reset.
module tb_inst_fetch_queue;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   inst_fetch_queue_if #(.DEPTH(4), .BUS_W(65)) ifq_bus ();

   inst_fetch_queue #(.DEPTH(4), .BUS_W(65)) dut (
      .clk    (clk),
      .resetn (resetn),
      .ifq    (ifq_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [64:0] mk(input logic [31:0] pc, input logic adef);
      return {adef, pc ^ 32'h1234_5678, pc};
   endfunction

   // Apply one cycle of inputs just after a rising edge, then let them settle.
   task automatic cyc(input logic v, input logic [64:0] b, input logic da,
                      input logic ex, input logic er, input logic br);
      @(posedge clk);
      #1;
      ifq_bus.fs_to_ds_valid = v;
      ifq_bus.fs_to_ds_bus   = b;
      ifq_bus.ds_allowin     = da;
      ifq_bus.wb_ex          = ex;
      ifq_bus.ertn_flush     = er;
      ifq_bus.br_taken       = br;
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifq_bus.q_to_ds_valid); end
      n_cmp++; if (ifq_bus.q_to_ds_bus !== 65'd0) begin n_err++; $display("FAIL reset_bus: got %h want 0", ifq_bus.q_to_ds_bus); end
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", ifq_bus.ifq_allowin); end
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ifq_bus.ifq_count); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_stream();
      logic        exp_v;
      logic [64:0] exp_b;
      for (int k = 0; k < 10; k++) begin
         cyc(k < 8, mk(32'h1c00_0000 + 32'(4 * k), 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
         exp_v = (k >= 1) && (k <= 8);
         exp_b = mk(32'h1c00_0000 + 32'(4 * (k - 1)), 1'b0);
         n_cmp++; if (ifq_bus.q_to_ds_valid !== exp_v) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want %b", k, ifq_bus.q_to_ds_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (ifq_bus.q_to_ds_bus !== exp_b) begin n_err++; $display("FAIL stream_bus[%0d]: got %h want %h", k, ifq_bus.q_to_ds_bus, exp_b); end
         end
         n_cmp++; if (ifq_bus.ifq_count !== {2'b00, exp_v}) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, ifq_bus.ifq_count, exp_v); end
      end
   endtask

   // Fill to full with decode stalled, hold the fifth at fetch, then drain across the wrap.
   task automatic test_full_wrap();
      logic        drv_v  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] drv_pc [11] = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h10, 32'h10, 32'h00, 32'h00, 32'h00, 32'h00};
      logic        drv_da [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic        exp_al [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [2:0]  exp_ct [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      logic [31:0] exp_pc [11] = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h00};
      logic        exp_v;
      logic [64:0] exp_b;
      for (int k = 0; k < 11; k++) begin
         cyc(drv_v[k], mk(32'h1c00_0000 + drv_pc[k], 1'b0), drv_da[k], 1'b0, 1'b0, 1'b0);
         exp_v = (exp_ct[k] != 3'd0);
         exp_b = mk(32'h1c00_0000 + exp_pc[k], 1'b0);
         n_cmp++; if (ifq_bus.ifq_allowin !== exp_al[k]) begin n_err++; $display("FAIL full_allowin[%0d]: got %b want %b", k, ifq_bus.ifq_allowin, exp_al[k]); end
         n_cmp++; if (ifq_bus.ifq_count !== exp_ct[k]) begin n_err++; $display("FAIL full_count[%0d]: got %0d want %0d", k, ifq_bus.ifq_count, exp_ct[k]); end
         n_cmp++; if (ifq_bus.q_to_ds_valid !== exp_v) begin n_err++; $display("FAIL full_valid[%0d]: got %b want %b", k, ifq_bus.q_to_ds_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (ifq_bus.q_to_ds_bus !== exp_b) begin n_err++; $display("FAIL full_bus[%0d]: got %h want %h", k, ifq_bus.q_to_ds_bus, exp_b); end
         end
      end
   endtask

   task automatic test_flush_branch();
      logic [64:0] e_b;
      e_b = mk(32'h1c00_0140, 1'b0);
      cyc(1'b1, mk(32'h1c00_0100, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, mk(32'h1c00_0104, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, mk(32'h1c00_0108, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, mk(32'h1c00_010c, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL br_valid_during: got %b want 0", ifq_bus.q_to_ds_valid); end
      n_cmp++; if (ifq_bus.ifq_count !== 3'd3) begin n_err++; $display("FAIL br_count_before: got %0d want 3", ifq_bus.ifq_count); end
      cyc(1'b0, 65'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL br_count_after: got %0d want 0", ifq_bus.ifq_count); end
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL br_allowin_after: got %b want 1", ifq_bus.ifq_allowin); end
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL br_valid_after: got %b want 0", ifq_bus.q_to_ds_valid); end
      cyc(1'b1, e_b, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL br_next_valid: got %b want 1", ifq_bus.q_to_ds_valid); end
      n_cmp++; if (ifq_bus.q_to_ds_bus !== e_b) begin n_err++; $display("FAIL br_next_bus: got %h want %h", ifq_bus.q_to_ds_bus, e_b); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL br_drained: got %0d want 0", ifq_bus.ifq_count); end
   endtask

   task automatic test_adef_hold();
      logic [64:0] x_b;
      logic [64:0] y_b;
      x_b = mk(32'h1c00_0002, 1'b1);
      y_b = mk(32'h1c00_0200, 1'b0);
      cyc(1'b1, x_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL adef_allowin_pre: got %b want 1", ifq_bus.ifq_allowin); end
      cyc(1'b1, y_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b0) begin n_err++; $display("FAIL adef_allowin_hold: got %b want 0", ifq_bus.ifq_allowin); end
      n_cmp++; if (ifq_bus.q_to_ds_bus !== x_b) begin n_err++; $display("FAIL adef_bus: got %h want %h", ifq_bus.q_to_ds_bus, x_b); end
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL adef_valid: got %b want 1", ifq_bus.q_to_ds_valid); end
      cyc(1'b1, y_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL adef_count_drained: got %0d want 0", ifq_bus.ifq_count); end
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b0) begin n_err++; $display("FAIL adef_allowin_empty: got %b want 0", ifq_bus.ifq_allowin); end
      cyc(1'b1, y_b, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b0) begin n_err++; $display("FAIL adef_allowin_exc: got %b want 0", ifq_bus.ifq_allowin); end
      cyc(1'b1, y_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL adef_allowin_post: got %b want 1", ifq_bus.ifq_allowin); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.q_to_ds_bus !== y_b) begin n_err++; $display("FAIL adef_resume_bus: got %h want %h", ifq_bus.q_to_ds_bus, y_b); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL adef_resume_count: got %0d want 0", ifq_bus.ifq_count); end
   endtask

   task automatic test_flush_full_ertn();
      logic [64:0] f5_b;
      f5_b = mk(32'h1c00_0314, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, mk(32'h1c00_0300 + 32'(4 * k), 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cyc(1'b1, mk(32'h1c00_0310, 1'b0), 1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd4) begin n_err++; $display("FAIL ertn_count_full: got %0d want 4", ifq_bus.ifq_count); end
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL ertn_valid_during: got %b want 0", ifq_bus.q_to_ds_valid); end
      cyc(1'b1, f5_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL ertn_count_after: got %0d want 0", ifq_bus.ifq_count); end
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL ertn_allowin_after: got %b want 1", ifq_bus.ifq_allowin); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.q_to_ds_bus !== f5_b) begin n_err++; $display("FAIL ertn_next_bus: got %h want %h", ifq_bus.q_to_ds_bus, f5_b); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [64:0] z_b;
      z_b = mk(32'h1c00_0400, 1'b0);
      cyc(1'b1, mk(32'h1c00_0380, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, mk(32'h1c00_0384, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 65'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd2) begin n_err++; $display("FAIL arst_count_before: got %0d want 2", ifq_bus.ifq_count); end
      #1;
      resetn = 1'b0;
      #1;
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", ifq_bus.q_to_ds_valid); end
      n_cmp++; if (ifq_bus.q_to_ds_bus !== 65'd0) begin n_err++; $display("FAIL arst_bus: got %h want 0", ifq_bus.q_to_ds_bus); end
      n_cmp++; if (ifq_bus.ifq_allowin !== 1'b1) begin n_err++; $display("FAIL arst_allowin: got %b want 1", ifq_bus.ifq_allowin); end
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", ifq_bus.ifq_count); end
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cyc(1'b1, z_b, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL arst_push_valid: got %b want 0", ifq_bus.q_to_ds_valid); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.q_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL arst_pop_valid: got %b want 1", ifq_bus.q_to_ds_valid); end
      n_cmp++; if (ifq_bus.q_to_ds_bus !== z_b) begin n_err++; $display("FAIL arst_pop_bus: got %h want %h", ifq_bus.q_to_ds_bus, z_b); end
      cyc(1'b0, 65'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (ifq_bus.ifq_count !== 3'd0) begin n_err++; $display("FAIL arst_drained: got %0d want 0", ifq_bus.ifq_count); end
   endtask

   initial begin
      ifq_bus.fs_to_ds_valid = 1'b0;
      ifq_bus.fs_to_ds_bus   = 65'd0;
      ifq_bus.ds_allowin     = 1'b0;
      ifq_bus.wb_ex          = 1'b0;
      ifq_bus.ertn_flush     = 1'b0;
      ifq_bus.br_taken       = 1'b0;
      test_reset();
      test_stream();
      test_full_wrap();
      test_flush_branch();
      test_adef_hold();
      test_flush_full_ertn();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_inst_fetch_queue
